// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// opcode encodings, flag bit positions and the arbiter state type.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: ADD/SUB/AND/OR with NZCV flags.
// Any opcode with op[2] set is illegal and yields zero result/flags with err.
module alu
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic [N-1:0] result_o,
   output logic [3:0]   flags_o,
   output logic         err_o
);

   logic [N-1:0] bSel;
   logic         carryIn;
   logic [N:0]   sumExt;
   logic         carry;
   logic         overflow;

   // SUB is a + ~b + 1, so the carry-out reads as "no borrow"
   assign bSel    = (op_i == OP_SUB) ? ~b_i : b_i;
   assign carryIn = (op_i == OP_SUB);
   assign sumExt  = {1'b0, a_i} + {1'b0, bSel} + {{N{1'b0}}, carryIn};

   always_comb begin
      result_o = '0;
      flags_o  = '0;
      err_o    = 1'b0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op_i)
         OP_ADD, OP_SUB: begin
            result_o = sumExt[N-1:0];
            carry    = sumExt[N];
            overflow = (a_i[N-1] == bSel[N-1]) && (sumExt[N-1] != a_i[N-1]);
         end
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         default: err_o = 1'b1;
      endcase
      if (!err_o) begin
         flags_o[FLAG_N] = result_o[N-1];
         flags_o[FLAG_Z] = (result_o == '0);
         flags_o[FLAG_C] = carry;
         flags_o[FLAG_V] = overflow;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// each accepted operation returns one tagged response after two cycles.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req0_valid_i,
   output logic         req0_ready_o,
   input  logic [N-1:0] req0_a_i,
   input  logic [N-1:0] req0_b_i,
   input  logic [2:0]   req0_op_i,
   input  logic         req1_valid_i,
   output logic         req1_ready_o,
   input  logic [N-1:0] req1_a_i,
   input  logic [N-1:0] req1_b_i,
   input  logic [2:0]   req1_op_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic         rsp_id_o,
   output logic [N-1:0] rsp_result_o,
   output logic [3:0]   rsp_flags_o,
   output logic         rsp_err_o
);

   arb_state_t   state_q, state_d;
   logic         lastGrant_q, lastGrant_d;
   logic [N-1:0] opA_q, opA_d;
   logic [N-1:0] opB_q, opB_d;
   logic [2:0]   op_q, op_d;
   logic         id_q, id_d;
   logic         rspValid_q, rspValid_d;
   logic         rspId_q, rspId_d;
   logic [N-1:0] rspResult_q, rspResult_d;
   logic [3:0]   rspFlags_q, rspFlags_d;
   logic         rspErr_q, rspErr_d;

   logic         grant;
   logic         accept;
   logic [N-1:0] aluResult;
   logic [3:0]   aluFlags;
   logic         aluErr;

   alu #(.N(N)) uAlu (
      .a_i      (opA_q),
      .b_i      (opB_q),
      .op_i     (op_q),
      .result_o (aluResult),
      .flags_o  (aluFlags),
      .err_o    (aluErr)
   );

   // A lone requester always wins; on a tie the one not served last wins
   always_comb begin
      if (req0_valid_i && req1_valid_i) grant = ~lastGrant_q;
      else                              grant = req1_valid_i;
   end

   // Ready is suppressed while reset is held so nothing is accepted then
   assign req0_ready_o = (state_q == IDLE) && !rst_i && !grant && req0_valid_i;
   assign req1_ready_o = (state_q == IDLE) && !rst_i &&  grant && req1_valid_i;
   assign accept       = req0_ready_o || req1_ready_o;

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      op_d        = op_q;
      id_d        = id_q;
      rspValid_d  = rspValid_q;
      rspId_d     = rspId_q;
      rspResult_d = rspResult_q;
      rspFlags_d  = rspFlags_q;
      rspErr_d    = rspErr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               opA_d       = grant ? req1_a_i  : req0_a_i;
               opB_d       = grant ? req1_b_i  : req0_b_i;
               op_d        = grant ? req1_op_i : req0_op_i;
               id_d        = grant;
               lastGrant_d = grant;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            rspValid_d  = 1'b1;
            rspId_d     = id_q;
            rspResult_d = aluResult;
            rspFlags_d  = aluFlags;
            rspErr_d    = aluErr;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         opA_q       <= '0;
         opB_q       <= '0;
         op_q        <= '0;
         id_q        <= 1'b0;
         rspValid_q  <= 1'b0;
         rspId_q     <= 1'b0;
         rspResult_q <= '0;
         rspFlags_q  <= '0;
         rspErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         op_q        <= op_d;
         id_q        <= id_d;
         rspValid_q  <= rspValid_d;
         rspId_q     <= rspId_d;
         rspResult_q <= rspResult_d;
         rspFlags_q  <= rspFlags_d;
         rspErr_q    <= rspErr_d;
      end
   end

   assign rsp_valid_o  = rspValid_q;
   assign rsp_id_o     = rspId_q;
   assign rsp_result_o = rspResult_q;
   assign rsp_flags_o  = rspFlags_q;
   assign rsp_err_o    = rspErr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push an expected
// response from an integer-arithmetic model, responses pop and compare.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N = 4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req0_valid_i, req1_valid_i;
   logic         req0_ready_o, req1_ready_o;
   logic [N-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [2:0]   req0_op_i, req1_op_i;
   logic         rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
   logic [N-1:0] rsp_result_o;
   logic [3:0]   rsp_flags_o;

   typedef struct {
      logic         id;
      logic [N-1:0] result;
      logic [3:0]   flags;
      logic         err;
   } rsp_t;

   rsp_t scoreboard[$];
   logic grantLog[$];
   int   acceptCycle[$];
   int   cycleCount = 0;
   int   vectors = 0;
   int   miscompares = 0;

   alu_arbiter #(.N(N)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_a_i     (req0_a_i),
      .req0_b_i     (req0_b_i),
      .req0_op_i    (req0_op_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_a_i     (req1_a_i),
      .req1_b_i     (req1_b_i),
      .req1_op_i    (req1_op_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_result_o (rsp_result_o),
      .rsp_flags_o  (rsp_flags_o),
      .rsp_err_o    (rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycleCount++;

   // Reference model built from integer ranges rather than bit tricks
   function automatic rsp_t model(logic id, logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
      rsp_t r;
      int   ua, ub, sa, sb, s, ss;
      logic c, v;
      r.id = id; r.err = 1'b0; r.result = '0; r.flags = '0;
      c = 1'b0; v = 1'b0; s = 0; ss = 0;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      case (op)
         3'b000: begin
            s = ua + ub; ss = sa + sb;
            c = (s > (1 << N) - 1);
            v = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
            r.result = s[N-1:0];
         end
         3'b001: begin
            s = ua - ub; ss = sa - sb;
            c = (ua >= ub);
            v = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
            r.result = s[N-1:0];
         end
         3'b010: r.result = a & b;
         3'b011: r.result = a | b;
         default: r.err = 1'b1;
      endcase
      if (!r.err) r.flags = {r.result[N-1], (r.result == '0), c, v};
      return r;
   endfunction

   always @(negedge clk_i) begin
      if (!rst_i && req0_valid_i && req0_ready_o) begin
         scoreboard.push_back(model(1'b0, req0_a_i, req0_b_i, req0_op_i));
         grantLog.push_back(1'b0);
         acceptCycle.push_back(cycleCount);
      end
      if (!rst_i && req1_valid_i && req1_ready_o) begin
         scoreboard.push_back(model(1'b1, req1_a_i, req1_b_i, req1_op_i));
         grantLog.push_back(1'b1);
         acceptCycle.push_back(cycleCount);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clearQueues();
      scoreboard.delete();
      grantLog.delete();
      acceptCycle.delete();
   endtask

   task automatic test_reset();
      rst_i = 1'b1; rsp_ready_i = 1'b0;
      req0_a_i = 4'd7; req0_b_i = 4'd1; req0_op_i = OP_ADD; req0_valid_i = 1'b1;
      req1_a_i = 4'hC; req1_b_i = 4'hA; req1_op_i = OP_AND; req1_valid_i = 1'b1;
      tick(); tick();
      @(negedge clk_i);
      vectors++;
      if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: got %b%b expected 00", req0_ready_o, req1_ready_o);
      end
      vectors++;
      if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_rsp: got valid=%b id=%b res=%h flags=%b err=%b expected all 0",
                  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o);
      end
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL reset_first_grant: got ready0/1=%b%b expected 10", req0_ready_o, req1_ready_o);
      end
      rst_i = 1'b1;
      tick();
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      clearQueues();
   endtask

   task automatic test_single();
      rsp_t exp;
      rsp_ready_i = 1'b1;
      req0_a_i = 4'd7; req0_b_i = 4'd1; req0_op_i = OP_ADD; req0_valid_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (req0_ready_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL single_accept: got ready0=%b expected 1", req0_ready_o);
      end
      tick();
      req0_valid_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (rsp_valid_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_early: got rsp_valid=%b at t+1 expected 0", rsp_valid_o);
      end
      tick();
      @(negedge clk_i);
      vectors++;
      if (rsp_valid_o !== 1'b1 || scoreboard.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL single_latency: got rsp_valid=%b queued=%0d at t+2 expected 1 with 1 queued",
                  rsp_valid_o, scoreboard.size());
      end else begin
         exp = scoreboard.pop_front();
         vectors++;
         if ({rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== {exp.id, exp.result, exp.flags, exp.err}) begin
            miscompares++;
            $display("[TB] FAIL single_rsp: got id=%b res=%b flags=%b err=%b expected id=%b res=%b flags=%b err=%b",
                     rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, exp.id, exp.result, exp.flags, exp.err);
         end
         vectors++;
         if ({rsp_result_o, rsp_flags_o} !== 8'b1000_1001) begin
            miscompares++;
            $display("[TB] FAIL single_const: got res=%b flags=%b expected res=1000 flags=1001",
                     rsp_result_o, rsp_flags_o);
         end
      end
      tick();
   endtask

   task automatic test_alternate();
      rsp_t exp;
      int   popped = 0;
      rst_i = 1'b1; rsp_ready_i = 1'b1;
      req0_a_i = 4'd5; req0_b_i = 4'd5; req0_op_i = OP_SUB; req0_valid_i = 1'b1;
      req1_a_i = 4'hC; req1_b_i = 4'hA; req1_op_i = OP_AND; req1_valid_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      clearQueues();
      for (int i = 0; i < 40 && popped < 4; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            vectors++;
            if (scoreboard.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL alt_unexpected: got response id=%b with nothing queued", rsp_id_o);
            end else begin
               exp = scoreboard.pop_front();
               if ({rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== {exp.id, exp.result, exp.flags, exp.err}) begin
                  miscompares++;
                  $display("[TB] FAIL alt_rsp%0d: got id=%b res=%b flags=%b err=%b expected id=%b res=%b flags=%b err=%b",
                           popped, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o,
                           exp.id, exp.result, exp.flags, exp.err);
               end
            end
            popped++;
         end
      end
      tick();
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      vectors++;
      if (popped != 4 || grantLog.size() < 4) begin
         miscompares++;
         $display("[TB] FAIL alt_count: got %0d responses %0d grants expected 4 and 4", popped, grantLog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grantLog[i] !== i[0]) begin
               miscompares++;
               $display("[TB] FAIL alt_grant%0d: got id=%b expected %b", i, grantLog[i], i[0]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (acceptCycle[i+1] - acceptCycle[i] != 3) begin
               miscompares++;
               $display("[TB] FAIL alt_period%0d: got %0d cycles between accepts expected 3",
                        i, acceptCycle[i+1] - acceptCycle[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      rsp_t exp;
      logic got = 1'b0;
      clearQueues();
      rsp_ready_i = 1'b0;
      req1_a_i = 4'b0011; req1_b_i = 4'b0100; req1_op_i = OP_OR; req1_valid_i = 1'b1;
      @(negedge clk_i);
      tick();
      req1_valid_i = 1'b0;
      req0_a_i = 4'hF; req0_b_i = 4'h1; req0_op_i = OP_ADD; req0_valid_i = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk_i);
         got = rsp_valid_o;
      end
      vectors++;
      if (!got || scoreboard.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL bp_wait: got rsp_valid=%b queued=%0d expected 1 with 1 queued", rsp_valid_o, scoreboard.size());
         exp = model(1'b1, 4'b0011, 4'b0100, OP_OR);
      end else begin
         exp = scoreboard.pop_front();
      end
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, req0_ready_o, req1_ready_o} !==
             {1'b1, exp.id, exp.result, exp.flags, exp.err, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b id=%b res=%b flags=%b err=%b rdy=%b%b expected valid=1 id=%b res=%b flags=%b err=%b rdy=00",
                     k, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, req0_ready_o, req1_ready_o,
                     exp.id, exp.result, exp.flags, exp.err);
         end
         if (k < 4) @(negedge clk_i);
      end
      tick();
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({rsp_valid_o, req0_ready_o} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL bp_release: got valid=%b ready0=%b expected valid=1 ready0=0", rsp_valid_o, req0_ready_o);
      end
      tick();
      @(negedge clk_i);
      vectors++;
      if ({rsp_valid_o, req0_ready_o} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL bp_done: got valid=%b ready0=%b expected valid=0 ready0=1", rsp_valid_o, req0_ready_o);
      end
      tick();
      req0_valid_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk_i);
         got = rsp_valid_o;
      end
      vectors++;
      if (!got || scoreboard.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL bp_next_wait: got rsp_valid=%b queued=%0d expected 1 with 1 queued", rsp_valid_o, scoreboard.size());
      end else begin
         exp = scoreboard.pop_front();
         if ({rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== {exp.id, exp.result, exp.flags, exp.err}) begin
            miscompares++;
            $display("[TB] FAIL bp_next_rsp: got id=%b res=%b flags=%b err=%b expected id=%b res=%b flags=%b err=%b",
                     rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, exp.id, exp.result, exp.flags, exp.err);
         end
      end
      tick();
   endtask

   task automatic test_illegal();
      rsp_t exp;
      logic got = 1'b0;
      clearQueues();
      rsp_ready_i = 1'b1;
      req1_a_i = 4'hF; req1_b_i = 4'hF; req1_op_i = 3'b100; req1_valid_i = 1'b1;
      @(negedge clk_i);
      tick();
      req1_valid_i = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk_i);
         got = rsp_valid_o;
      end
      vectors++;
      if (!got || scoreboard.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL illegal_wait: got rsp_valid=%b queued=%0d expected 1 with 1 queued", rsp_valid_o, scoreboard.size());
      end else begin
         exp = scoreboard.pop_front();
         if ({rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== {exp.id, exp.result, exp.flags, exp.err}) begin
            miscompares++;
            $display("[TB] FAIL illegal_rsp: got id=%b res=%b flags=%b err=%b expected id=%b res=%b flags=%b err=%b",
                     rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, exp.id, exp.result, exp.flags, exp.err);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_t exp;
      logic seen = 1'b0;
      clearQueues();
      rsp_ready_i = 1'b1;
      req0_a_i = 4'd3; req0_b_i = 4'd2; req0_op_i = OP_ADD; req0_valid_i = 1'b1;
      @(negedge clk_i);
      tick();
      req0_valid_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      clearQueues();
      @(negedge clk_i);
      vectors++;
      if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrst_clear: got valid=%b id=%b res=%h flags=%b err=%b expected all 0",
                  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midrst_ghost: got a response after reset expected none");
      end
      tick();
      req0_valid_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (req0_ready_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midrst_reissue: got ready0=%b expected 1", req0_ready_o);
      end
      tick();
      req0_valid_i = 1'b0;
      tick();
      @(negedge clk_i);
      vectors++;
      if (rsp_valid_o !== 1'b1 || scoreboard.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL midrst_latency: got rsp_valid=%b queued=%0d at t+2 expected 1 with 1 queued",
                  rsp_valid_o, scoreboard.size());
      end else begin
         exp = scoreboard.pop_front();
         vectors++;
         if ({rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o} !== {exp.id, exp.result, exp.flags, exp.err}) begin
            miscompares++;
            $display("[TB] FAIL midrst_rsp: got id=%b res=%b flags=%b err=%b expected id=%b res=%b flags=%b err=%b",
                     rsp_id_o, rsp_result_o, rsp_flags_o, rsp_err_o, exp.id, exp.result, exp.flags, exp.err);
         end
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_i = 1'b1; rsp_ready_i = 1'b0;
      req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_op_i = '0;
      req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; req1_op_i = '0;
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
